// File: rtl/hazard_controller.sv
// ============================================================================
// Module   : hazard_controller
// Purpose  : RV32I 5-stage hazard scheduler: forwarding, load-use, branch
//            flush and data-memory wait FSM with timeout.
//            Optional HAZARD_PERF_CNT_EN adds stall/flush performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_controller #(
    parameter int MEM_TIMEOUT_CYC = 64,
    parameter int CNT_W           = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  Rs1D_i,
    input  logic [4:0]  Rs2D_i,
    input  logic [4:0]  Rs1E_i,
    input  logic [4:0]  Rs2E_i,
    input  logic [4:0]  RdE_i,
    input  logic [4:0]  RdM_i,
    input  logic [4:0]  RdW_i,
    input  logic        RegWriteM_i,
    input  logic        RegWriteW_i,
    input  logic        LoadE_i,
    input  logic        PCSrcE_i,
    input  logic        MemReqM_i,
    input  logic        MemReadyM_i,
    output logic        StallF_o,
    output logic        StallD_o,
    output logic        StallE_o,
    output logic        StallM_o,
    output logic        FlushD_o,
    output logic        FlushE_o,
    output logic        FlushW_o,
    output logic [1:0]  ForwardAE_o,
    output logic [1:0]  ForwardBE_o,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] StallCycles_o,
    output logic [31:0] FlushCount_o,
`endif
    output logic        MemTimeout_o
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(MEM_TIMEOUT_CYC - 1);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
    logic               w_memwait;
    logic               w_lduse;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       rw_m,
                                           input logic [4:0] rd_m,
                                           input logic       rw_w,
                                           input logic [4:0] rd_w);
        if (rw_m && (rd_m != 5'd0) && (rd_m == rs))
            return 2'b10;
        else if (rw_w && (rd_w != 5'd0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_RUN;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // The aborted access is released on the timeout cycle, so it must not
    // re-enter WAIT while its request is still asserted.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            S_RUN: begin
                if (MemReqM_i && !MemReadyM_i && !timeout_q) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (MemReadyM_i) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == C_CNT_MAX) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        w_lduse   = LoadE_i && (RdE_i != 5'd0) &&
                    ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
        // A ready WAIT cycle completes the access, so MEM may advance.
        w_memwait = ((state_q == S_RUN) && MemReqM_i && !MemReadyM_i && !timeout_q) ||
                    ((state_q == S_WAIT) && !MemReadyM_i);

        StallF_o    = 1'b0;
        StallD_o    = 1'b0;
        StallE_o    = 1'b0;
        StallM_o    = 1'b0;
        FlushD_o    = 1'b0;
        FlushE_o    = 1'b0;
        FlushW_o    = 1'b0;
        ForwardAE_o = 2'b00;
        ForwardBE_o = 2'b00;

        if (!rst_i) begin
            ForwardAE_o = fwd_sel(Rs1E_i, RegWriteM_i, RdM_i, RegWriteW_i, RdW_i);
            ForwardBE_o = fwd_sel(Rs2E_i, RegWriteM_i, RdM_i, RegWriteW_i, RdW_i);
            if (w_memwait) begin
                StallF_o = 1'b1;
                StallD_o = 1'b1;
                StallE_o = 1'b1;
                StallM_o = 1'b1;
                FlushW_o = 1'b1;
            end else if (timeout_q) begin
                FlushW_o = 1'b1;
            end else if (PCSrcE_i) begin
                FlushD_o = 1'b1;
                FlushE_o = 1'b1;
            end else if (w_lduse) begin
                StallF_o = 1'b1;
                StallD_o = 1'b1;
                FlushE_o = 1'b1;
            end
        end
    end

    assign MemTimeout_o = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (StallF_o)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (FlushD_o || FlushE_o)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign StallCycles_o = stall_cnt_q;
    assign FlushCount_o  = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_controller.sv
// ============================================================================
// Module   : tb_hazard_controller
// Purpose  : Directed self-checking bench for hazard_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_controller;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i;
    logic       RegWriteM_i, RegWriteW_i, LoadE_i, PCSrcE_i, MemReqM_i, MemReadyM_i;
    logic       StallF_o, StallD_o, StallE_o, StallM_o;
    logic       FlushD_o, FlushE_o, FlushW_o;
    logic [1:0] ForwardAE_o, ForwardBE_o;
    logic       MemTimeout_o;
    logic [6:0] w_ctl;

    int n_vec = 0;
    int n_err = 0;

    // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    assign w_ctl = {StallF_o, StallD_o, StallE_o, StallM_o, FlushD_o, FlushE_o, FlushW_o};

    always #5 clk_i = ~clk_i;

    hazard_controller #(.MEM_TIMEOUT_CYC(4), .CNT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i), .Rs1E_i(Rs1E_i), .Rs2E_i(Rs2E_i),
        .RdE_i(RdE_i), .RdM_i(RdM_i), .RdW_i(RdW_i),
        .RegWriteM_i(RegWriteM_i), .RegWriteW_i(RegWriteW_i),
        .LoadE_i(LoadE_i), .PCSrcE_i(PCSrcE_i),
        .MemReqM_i(MemReqM_i), .MemReadyM_i(MemReadyM_i),
        .StallF_o(StallF_o), .StallD_o(StallD_o), .StallE_o(StallE_o), .StallM_o(StallM_o),
        .FlushD_o(FlushD_o), .FlushE_o(FlushE_o), .FlushW_o(FlushW_o),
        .ForwardAE_o(ForwardAE_o), .ForwardBE_o(ForwardBE_o),
        .MemTimeout_o(MemTimeout_o)
    );

    task automatic clear_inputs();
        Rs1D_i = 5'd0; Rs2D_i = 5'd0; Rs1E_i = 5'd0; Rs2E_i = 5'd0;
        RdE_i = 5'd0; RdM_i = 5'd0; RdW_i = 5'd0;
        RegWriteM_i = 1'b0; RegWriteW_i = 1'b0; LoadE_i = 1'b0;
        PCSrcE_i = 1'b0; MemReqM_i = 1'b0; MemReadyM_i = 1'b0;
    endtask

    // Inputs change 2 time units after a rising edge; checks follow 1 unit later.
    task automatic next_cycle();
        @(posedge clk_i);
        #2;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        clear_inputs();
        RegWriteM_i = 1'b1; RdM_i = 5'd4; Rs1E_i = 5'd4;
        MemReqM_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        n_vec++;
        if (w_ctl !== 7'b0 || MemTimeout_o !== 1'b0 || ForwardAE_o !== 2'b00) begin
            n_err++;
            $display("FAIL reset_outputs: ctl=%b to=%b fa=%b, want ctl=0000000 to=0 fa=00",
                     w_ctl, MemTimeout_o, ForwardAE_o);
        end
        clear_inputs();
        next_cycle();
        rst_i = 1'b0;
        #1;
        n_vec++;
        if (w_ctl !== 7'b0 || MemTimeout_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: ctl=%b to=%b, want 0000000/0", w_ctl, MemTimeout_o);
        end
    endtask

    task automatic test_forwarding();
        next_cycle();
        clear_inputs();
        RegWriteM_i = 1'b1; RdM_i = 5'd5; RegWriteW_i = 1'b1; RdW_i = 5'd5;
        Rs1E_i = 5'd5; Rs2E_i = 5'd9;
        #1;
        n_vec++;
        if (ForwardAE_o !== 2'b10 || ForwardBE_o !== 2'b00) begin
            n_err++;
            $display("FAIL fwd_mem_priority: fa=%b fb=%b, want 10/00", ForwardAE_o, ForwardBE_o);
        end
        RdM_i = 5'd0;
        #1;
        n_vec++;
        if (ForwardAE_o !== 2'b01) begin
            n_err++;
            $display("FAIL fwd_wb_rdm0: fa=%b, want 01", ForwardAE_o);
        end
        Rs1E_i = 5'd0; RdW_i = 5'd0;
        #1;
        n_vec++;
        if (ForwardAE_o !== 2'b00) begin
            n_err++;
            $display("FAIL fwd_x0: fa=%b, want 00", ForwardAE_o);
        end
        RdM_i = 5'd9; RegWriteM_i = 1'b0; RdW_i = 5'd9; RegWriteW_i = 1'b1;
        #1;
        n_vec++;
        if (ForwardBE_o !== 2'b01 || w_ctl !== 7'b0) begin
            n_err++;
            $display("FAIL fwd_b_wb: fb=%b ctl=%b, want 01/0000000", ForwardBE_o, w_ctl);
        end
        RegWriteM_i = 1'b1;
        #1;
        n_vec++;
        if (ForwardBE_o !== 2'b10) begin
            n_err++;
            $display("FAIL fwd_b_mem: fb=%b, want 10", ForwardBE_o);
        end
    endtask

    task automatic test_load_use();
        next_cycle();
        clear_inputs();
        LoadE_i = 1'b1; RdE_i = 5'd7; Rs2D_i = 5'd7; Rs1D_i = 5'd2;
        #1;
        n_vec++;
        if (w_ctl !== 7'b1100010) begin
            n_err++;
            $display("FAIL lduse_stall: ctl=%b, want 1100010", w_ctl);
        end
        next_cycle();
        LoadE_i = 1'b0;
        #1;
        n_vec++;
        if (w_ctl !== 7'b0) begin
            n_err++;
            $display("FAIL lduse_release: ctl=%b, want 0000000", w_ctl);
        end
        LoadE_i = 1'b1; RdE_i = 5'd0; Rs1D_i = 5'd0; Rs2D_i = 5'd0;
        #1;
        n_vec++;
        if (w_ctl !== 7'b0) begin
            n_err++;
            $display("FAIL lduse_x0: ctl=%b, want 0000000", w_ctl);
        end
    endtask

    task automatic test_branch_lduse();
        next_cycle();
        clear_inputs();
        PCSrcE_i = 1'b1; LoadE_i = 1'b1; RdE_i = 5'd3; Rs1D_i = 5'd3;
        #1;
        n_vec++;
        if (w_ctl !== 7'b0000110) begin
            n_err++;
            $display("FAIL branch_over_lduse: ctl=%b, want 0000110", w_ctl);
        end
    endtask

    task automatic test_mem_wait();
        next_cycle();
        clear_inputs();
        MemReqM_i = 1'b1; MemReadyM_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            PCSrcE_i = (i == 1);
            #1;
            n_vec++;
            if (w_ctl !== 7'b1111001 || MemTimeout_o !== 1'b0) begin
                n_err++;
                $display("FAIL memwait_cyc%0d: ctl=%b to=%b, want 1111001/0", i, w_ctl, MemTimeout_o);
            end
            next_cycle();
        end
        PCSrcE_i = 1'b0;
        MemReadyM_i = 1'b1;
        #1;
        n_vec++;
        if (w_ctl !== 7'b0 || MemTimeout_o !== 1'b0) begin
            n_err++;
            $display("FAIL memwait_ready: ctl=%b to=%b, want 0000000/0", w_ctl, MemTimeout_o);
        end
        next_cycle();
        MemReqM_i = 1'b0; MemReadyM_i = 1'b0;
        #1;
        n_vec++;
        if (w_ctl !== 7'b0 || MemTimeout_o !== 1'b0) begin
            n_err++;
            $display("FAIL memwait_after: ctl=%b to=%b, want 0000000/0", w_ctl, MemTimeout_o);
        end
    endtask

    task automatic test_zero_latency();
        next_cycle();
        clear_inputs();
        MemReqM_i = 1'b1; MemReadyM_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_vec++;
            if (w_ctl !== 7'b0) begin
                n_err++;
                $display("FAIL zero_latency_%0d: ctl=%b, want 0000000", i, w_ctl);
            end
            next_cycle();
        end
    endtask

    task automatic test_timeout();
        clear_inputs();
        MemReqM_i = 1'b1; MemReadyM_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++;
            if (w_ctl !== 7'b1111001 || MemTimeout_o !== 1'b0) begin
                n_err++;
                $display("FAIL timeout_wait%0d: ctl=%b to=%b, want 1111001/0", i, w_ctl, MemTimeout_o);
            end
            next_cycle();
        end
        #1;
        n_vec++;
        if (MemTimeout_o !== 1'b1 || w_ctl !== 7'b0000001) begin
            n_err++;
            $display("FAIL timeout_pulse: to=%b ctl=%b, want 1/0000001", MemTimeout_o, w_ctl);
        end
        MemReqM_i = 1'b0;
        next_cycle();
        #1;
        n_vec++;
        if (MemTimeout_o !== 1'b0 || w_ctl !== 7'b0) begin
            n_err++;
            $display("FAIL timeout_single: to=%b ctl=%b, want 0/0000000", MemTimeout_o, w_ctl);
        end
    endtask

    task automatic test_reset_mid_wait();
        next_cycle();
        clear_inputs();
        MemReqM_i = 1'b1; MemReadyM_i = 1'b0;
        next_cycle();
        // WAIT cycle 2: reset arrives between clock edges
        rst_i = 1'b1;
        #1;
        n_vec++;
        if (w_ctl !== 7'b0 || MemTimeout_o !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_wait: ctl=%b to=%b, want 0000000/0", w_ctl, MemTimeout_o);
        end
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            #1;
            n_vec++;
            if (MemTimeout_o !== 1'b0 || w_ctl !== 7'b0) begin
                n_err++;
                $display("FAIL rst_hold%0d: to=%b ctl=%b, want 0/0000000", i, MemTimeout_o, w_ctl);
            end
        end
        MemReqM_i = 1'b0;
        rst_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            #1;
            n_vec++;
            if (w_ctl !== 7'b0 || MemTimeout_o !== 1'b0) begin
                n_err++;
                $display("FAIL rst_release_run%0d: ctl=%b to=%b, want 0000000/0", i, w_ctl, MemTimeout_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_lduse();
        test_mem_wait();
        test_zero_latency();
        test_timeout();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
